// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader -- serial configuration loader and sequencer for NUM_CLB CLBs.
//
// Parses a bitstream of the form: [junk] PREAMBLE, 8-bit frame count, then one
// frame per CLB (CFG_BITS data bits MSB first followed by an even-parity bit).
// Committed frames are held in CFG and flagged in CFG_VALID.
//
// Ports:
//   K          in   clock, rising edge
//   RST        in   synchronous reset, active-high
//   PROG       in   single-cycle start/restart of a load (beats everything but RST)
//   DIN        in   serial bitstream data
//   DVALID     in   DIN is consumed only on edges where DVALID=1
//   CFG        out  configuration words, CLB i uses CFG[i*CFG_BITS +: CFG_BITS]
//   CFG_VALID  out  bit i set once frame i is committed
//   FRAME_IDX  out  index of the frame currently being loaded
//   BUSY       out  high while in PREAMBLE, LENGTH or FRAME
//   DONE       out  load completed successfully
//   ERR        out  load aborted (length mismatch or parity error)
//   RDBK       in   readback start pulse (readback build only)
//   DOUT       out  readback serial data (readback build only, else 0)
//   RDBK_BUSY  out  readback in progress (readback build only, else 0)
//
// Optional feature: define CLB_CFG_READBACK_EN to enable serial readback of
// all committed frames (each followed by a recomputed even-parity bit).

module clb_cfg_loader #(
    parameter int unsigned NUM_CLB  = 2,
    parameter int unsigned CFG_BITS = 37,
    parameter logic [7:0]  PREAMBLE = 8'hF2
) (
    input  logic                         K,
    input  logic                         RST,
    input  logic                         PROG,
    input  logic                         DIN,
    input  logic                         DVALID,
    output logic [NUM_CLB*CFG_BITS-1:0]  CFG,
    output logic [NUM_CLB-1:0]           CFG_VALID,
    output logic [7:0]                   FRAME_IDX,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         ERR,
    input  logic                         RDBK,
    output logic                         DOUT,
    output logic                         RDBK_BUSY
);

    localparam int unsigned BW = $clog2(CFG_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_LENGTH,
        S_FRAME,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                       state_q, state_d;
    // Last 7 accepted bits; with the incoming bit this forms the 8-bit window
    // used both for preamble matching and for the frame-count byte.
    logic [6:0]                   win_q, win_d;
    logic [2:0]                   len_cnt_q, len_cnt_d;
    logic [BW-1:0]                bit_cnt_q, bit_cnt_d;
    logic [CFG_BITS-1:0]          sr_q, sr_d;
    logic                         par_q, par_d;
    logic [NUM_CLB*CFG_BITS-1:0]  cfg_q, cfg_d;
    logic [NUM_CLB-1:0]           valid_q, valid_d;
    logic [7:0]                   idx_q, idx_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        len_cnt_d = len_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        par_d     = par_q;
        cfg_d     = cfg_q;
        valid_d   = valid_q;
        idx_d     = idx_q;

        if (PROG) begin
            state_d   = S_PREAMBLE;
            win_d     = '0;
            len_cnt_d = '0;
            bit_cnt_d = '0;
            sr_d      = '0;
            par_d     = 1'b0;
            cfg_d     = '0;
            valid_d   = '0;
            idx_d     = '0;
        end else if (DVALID) begin
            case (state_q)
                S_PREAMBLE: begin
                    win_d = {win_q[5:0], DIN};
                    if ({win_q, DIN} == PREAMBLE) begin
                        state_d   = S_LENGTH;
                        len_cnt_d = '0;
                    end
                end
                S_LENGTH: begin
                    win_d     = {win_q[5:0], DIN};
                    len_cnt_d = len_cnt_q + 3'd1;
                    if (len_cnt_q == 3'd7) begin
                        if ({win_q, DIN} == 8'(NUM_CLB)) begin
                            state_d   = S_FRAME;
                            idx_d     = '0;
                            bit_cnt_d = '0;
                            par_d     = 1'b0;
                        end else begin
                            state_d = S_ERROR;
                            valid_d = '0;
                        end
                    end
                end
                S_FRAME: begin
                    if (bit_cnt_q == BW'(CFG_BITS)) begin
                        // Parity bit: commit only when the whole frame checks out.
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                        if (par_q ^ DIN) begin
                            state_d = S_ERROR;
                            valid_d = '0;
                        end else begin
                            for (int unsigned i = 0; i < NUM_CLB; i++) begin
                                if (idx_q == 8'(i)) begin
                                    cfg_d[i*CFG_BITS +: CFG_BITS] = sr_q;
                                    valid_d[i]                    = 1'b1;
                                end
                            end
                            if (idx_q == 8'(NUM_CLB - 1)) begin
                                state_d = S_DONE;
                            end else begin
                                idx_d = idx_q + 8'd1;
                            end
                        end
                    end else begin
                        sr_d      = {sr_q[CFG_BITS-2:0], DIN};
                        par_d     = par_q ^ DIN;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == S_PREAMBLE) || (state_d == S_LENGTH) || (state_d == S_FRAME);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

`ifdef CLB_CFG_READBACK_EN
    logic                 rb_busy_q, rb_busy_d;
    logic [CFG_BITS:0]    rb_sr_q, rb_sr_d;
    logic [BW-1:0]        rb_bit_q, rb_bit_d;
    logic [7:0]           rb_clb_q, rb_clb_d;
    logic                 rb_start;
    logic [7:0]           rb_sel;
    logic [CFG_BITS-1:0]  rb_slice;

    always_comb begin
        rb_busy_d = rb_busy_q;
        rb_sr_d   = rb_sr_q;
        rb_bit_d  = rb_bit_q;
        rb_clb_d  = rb_clb_q;

        rb_start = (state_q == S_DONE) && RDBK && !rb_busy_q;
        // Slice to load next: frame 0 on start, otherwise the following frame.
        rb_sel   = rb_start ? 8'd0 : rb_clb_q + 8'd1;
        rb_slice = '0;
        for (int unsigned i = 0; i < NUM_CLB; i++) begin
            if (rb_sel == 8'(i)) begin
                rb_slice = cfg_q[i*CFG_BITS +: CFG_BITS];
            end
        end

        if (PROG) begin
            rb_busy_d = 1'b0;
            rb_sr_d   = '0;
            rb_bit_d  = '0;
            rb_clb_d  = '0;
        end else if (rb_start) begin
            rb_busy_d = 1'b1;
            rb_sr_d   = {rb_slice, ^rb_slice};
            rb_bit_d  = '0;
            rb_clb_d  = '0;
        end else if (rb_busy_q) begin
            if (rb_bit_q == BW'(CFG_BITS)) begin
                rb_bit_d = '0;
                if (rb_clb_q == 8'(NUM_CLB - 1)) begin
                    rb_busy_d = 1'b0;
                    rb_sr_d   = '0;
                end else begin
                    rb_clb_d = rb_clb_q + 8'd1;
                    rb_sr_d  = {rb_slice, ^rb_slice};
                end
            end else begin
                rb_sr_d  = {rb_sr_q[CFG_BITS-1:0], 1'b0};
                rb_bit_d = rb_bit_q + BW'(1);
            end
        end
    end

    assign DOUT      = rb_sr_q[CFG_BITS];
    assign RDBK_BUSY = rb_busy_q;
`else
    logic unused_rdbk;
    assign unused_rdbk = RDBK;
    assign DOUT        = 1'b0;
    assign RDBK_BUSY   = 1'b0;
`endif

    always_ff @(posedge K) begin
        if (RST) begin
            state_q   <= S_IDLE;
            win_q     <= '0;
            len_cnt_q <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            par_q     <= 1'b0;
            cfg_q     <= '0;
            valid_q   <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef CLB_CFG_READBACK_EN
            rb_busy_q <= 1'b0;
            rb_sr_q   <= '0;
            rb_bit_q  <= '0;
            rb_clb_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            len_cnt_q <= len_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            par_q     <= par_d;
            cfg_q     <= cfg_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef CLB_CFG_READBACK_EN
            rb_busy_q <= rb_busy_d;
            rb_sr_q   <= rb_sr_d;
            rb_bit_q  <= rb_bit_d;
            rb_clb_q  <= rb_clb_d;
`endif
        end
    end

    assign CFG       = cfg_q;
    assign CFG_VALID = valid_q;
    assign FRAME_IDX = idx_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule
